// File: rtl/trajectory_renderer.sv
// trajectory_renderer
//    Keeps a ring buffer of recent ball-centre points, with at most one point
//    committed per frame. Each scanned pixel is rendered as a square dot
//    colour where a live stored point covers it, and as 24'h000000
//    (transparent) elsewhere. Latency from hcount/vcount to pixel is fixed at
//    2 cycles.
//
//    Optional build macro: TRAJECTORY_FADE_EN
//       defined   : colour dims with point age (each channel >> min(age>>2,7)),
//                   and the newest covering point is selected.
//       undefined : every live hit renders COLOR; no age-to-shift logic.
module trajectory_renderer #(
   parameter int          DEPTH  = 16,
   parameter int          RADIUS = 2,
   parameter logic [23:0] COLOR  = 24'hFFFF00
) (
   input  logic        clk_in,
   input  logic        rst_in,
   input  logic [10:0] hcount_in,
   input  logic [9:0]  vcount_in,
   input  logic        frame_start_in,
   input  logic        point_valid_in,
   input  logic [10:0] point_x_in,
   input  logic [9:0]  point_y_in,
   input  logic        clear_in,
   output logic [23:0] trajectory_pixel_out,
   output logic [5:0]  count_out
);

   localparam int          AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [5:0]  DEPTH_CNT = 6'(DEPTH);
   localparam logic [11:0] RADIUS_W  = 12'(RADIUS);

   // Absolute difference of two non-negative coordinates, computed 12-bit
   // signed so a point near 0 never aliases with the far edge of the screen.
   function automatic logic [11:0] abs_diff(input logic [11:0] a, input logic [11:0] b);
      logic signed [11:0] d;
      d = $signed(a) - $signed(b);
      if (d < 12'sd0) begin
         return 12'(-d);
      end else begin
         return 12'(d);
      end
   endfunction

   // True when scan position (h,v) lies inside the dot centred on (x,y).
   function automatic logic dot_hit(input logic [10:0] h, input logic [9:0] v,
                                    input logic [10:0] x, input logic [9:0] y);
      logic [11:0] dx;
      logic [11:0] dy;
      dx = abs_diff({1'b0, h}, {1'b0, x});
      dy = abs_diff({2'b00, v}, {2'b00, y});
      return (dx <= RADIUS_W) && (dy <= RADIUS_W);
   endfunction

`ifdef TRAJECTORY_FADE_EN
   // Colour of a point of the given age: each channel shifted right by
   // min(age>>2, 7). A fully dimmed result is simply transparent.
   function automatic logic [23:0] age_color(input logic [AW-1:0] age);
      logic [5:0] quarter;
      logic [2:0] sh;
      quarter = 6'(age) >> 2;
      sh      = (quarter > 6'd7) ? 3'd7 : quarter[2:0];
      return {COLOR[23:16] >> sh, COLOR[15:8] >> sh, COLOR[7:0] >> sh};
   endfunction
`endif

   // ---------------------------------------------------------------------
   // Trail state
   // ---------------------------------------------------------------------
   logic [AW-1:0] wr_ptr_q,   wr_ptr_d;
   logic [5:0]    count_q,    count_d;
   logic          pend_q,     pend_d;
   logic [10:0]   pend_x_q,   pend_x_d;
   logic [9:0]    pend_y_q,   pend_y_d;
   logic          commit_s;
   logic          mem_we_s;

   logic [10:0]   x_mem [DEPTH];
   logic [9:0]    y_mem [DEPTH];

   // Pipeline state: hits re-ordered by age (bit 0 = newest), then colour.
   logic [DEPTH-1:0] hit_age_q, hit_age_d;
   logic [23:0]      pix_q,     pix_d;

   // Capture / commit / clear control; clear outranks commit and capture.
   always_comb begin
      commit_s = frame_start_in & pend_q;
      mem_we_s = commit_s & ~clear_in;
      wr_ptr_d = wr_ptr_q;
      count_d  = count_q;
      pend_d   = pend_q;
      pend_x_d = pend_x_q;
      pend_y_d = pend_y_q;
      if (clear_in) begin
         wr_ptr_d = {AW{1'b0}};
         count_d  = 6'd0;
         pend_d   = 1'b0;
      end else begin
         if (commit_s) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
            count_d  = (count_q == DEPTH_CNT) ? count_q : count_q + 6'd1;
         end else begin
            wr_ptr_d = wr_ptr_q;
            count_d  = count_q;
         end
         // A capture in the commit cycle belongs to the next frame.
         if (point_valid_in) begin
            pend_d   = 1'b1;
            pend_x_d = point_x_in;
            pend_y_d = point_y_in;
         end else if (commit_s) begin
            pend_d   = 1'b0;
         end else begin
            pend_d   = pend_q;
         end
      end
   end

   // Point RAM write at commit; contents beyond count are never rendered,
   // so the array carries no reset.
   always_ff @(posedge clk_in) begin
      if (mem_we_s) begin
         x_mem[wr_ptr_q] <= pend_x_q;
         y_mem[wr_ptr_q] <= pend_y_q;
      end
   end

   // Stage 1: per-slot dot test, stored in age order so stage 2 needs no
   // pointer arithmetic and is immune to a commit landing between stages.
   always_comb begin
      logic [AW-1:0] age_v;
      logic          live_v;
      hit_age_d = {DEPTH{1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
         age_v  = wr_ptr_q - AW'(1) - AW'(i);
         live_v = (6'(age_v) < count_q);
         // Ages are a permutation of slots, so each bit is written once.
         hit_age_d[age_v] = live_v &
                            dot_hit(hcount_in, vcount_in, x_mem[i], y_mem[i]);
      end
   end

`ifdef TRAJECTORY_FADE_EN
   // Stage 2: newest covering point wins, coloured by its age.
   always_comb begin
      logic          found_v;
      logic [AW-1:0] sel_v;
      found_v = 1'b0;
      sel_v   = {AW{1'b0}};
      for (int a = DEPTH - 1; a >= 0; a--) begin
         found_v = found_v | hit_age_q[a];
         sel_v   = hit_age_q[a] ? AW'(a) : sel_v;
      end
      pix_d = found_v ? age_color(sel_v) : 24'h000000;
   end
`else
   // Stage 2: any live covering point renders the trail colour.
   always_comb begin
      pix_d = (|hit_age_q) ? COLOR : 24'h000000;
   end
`endif

   // All state and registered outputs, async reset.
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         wr_ptr_q  <= {AW{1'b0}};
         count_q   <= 6'd0;
         pend_q    <= 1'b0;
         pend_x_q  <= 11'd0;
         pend_y_q  <= 10'd0;
         hit_age_q <= {DEPTH{1'b0}};
         pix_q     <= 24'h000000;
      end else begin
         wr_ptr_q  <= wr_ptr_d;
         count_q   <= count_d;
         pend_q    <= pend_d;
         pend_x_q  <= pend_x_d;
         pend_y_q  <= pend_y_d;
         hit_age_q <= hit_age_d;
         pix_q     <= pix_d;
      end
   end

   assign trajectory_pixel_out = pix_q;
   assign count_out            = count_q;

endmodule

// File: tb/tb_trajectory_renderer.sv
// Self-checking bench for trajectory_renderer (DEPTH=16, RADIUS=2,
// COLOR=24'hFFFF00). Stimulus pushes expectations with a due cycle into a
// scoreboard queue; a negedge monitor compares whatever is due.
module tb_trajectory_renderer;

   localparam int          DEPTH = 16;
   localparam logic [23:0] COL   = 24'hFFFF00;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [10:0] hcount = 11'd0;
   logic [9:0]  vcount = 10'd0;
   logic        frame_start = 1'b0;
   logic        point_valid = 1'b0;
   logic [10:0] point_x = 11'd0;
   logic [9:0]  point_y = 10'd0;
   logic        clear = 1'b0;
   logic [23:0] pixel;
   logic [5:0]  count;

   trajectory_renderer #(.DEPTH(DEPTH), .RADIUS(2), .COLOR(COL)) dut (
      .clk_in               (clk),
      .rst_in               (rst),
      .hcount_in            (hcount),
      .vcount_in            (vcount),
      .frame_start_in       (frame_start),
      .point_valid_in       (point_valid),
      .point_x_in           (point_x),
      .point_y_in           (point_y),
      .clear_in             (clear),
      .trajectory_pixel_out (pixel),
      .count_out            (count)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit          is_cnt;
      logic [23:0] exp;
      int          due;
      int          h;
      int          v;
   } exp_t;

   exp_t sb[$];
   int vectors     = 0;
   int miscompares = 0;

   // Monitor: compare every expectation whose due cycle is now.
   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].due == cyc) begin
            vectors++;
            if (sb[i].is_cnt) begin
               if ({18'd0, count} !== sb[i].exp) begin
                  miscompares++;
                  $display("FAIL count: got %0d want %0d (cycle %0d)", count, sb[i].exp, cyc);
               end
            end else begin
               if (pixel !== sb[i].exp) begin
                  miscompares++;
                  $display("FAIL pixel(%0d,%0d): got %h want %h (cycle %0d)",
                           sb[i].h, sb[i].v, pixel, sb[i].exp, cyc);
               end
            end
            sb.delete(i);
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input bit is_cnt, input logic [23:0] exp, input int due,
                           input int h, input int v);
      exp_t e;
      e.is_cnt = is_cnt; e.exp = exp; e.due = due; e.h = h; e.v = v;
      sb.push_back(e);
   endtask

   // Present a scan position; its pixel is due two edges later.
   task automatic expect_pix(input int h, input int v, input logic [23:0] exp);
      hcount = 11'(h);
      vcount = 10'(v);
      push_exp(1'b0, exp, cyc + 2, h, v);
      tick();
   endtask

   task automatic expect_cnt(input int exp);
      push_exp(1'b1, 24'(exp), cyc, 0, 0);
      tick();
   endtask

   task automatic push_point(input int x, input int y);
      point_valid = 1'b1;
      point_x     = 11'(x);
      point_y     = 10'(y);
      tick();
      point_valid = 1'b0;
   endtask

   task automatic frame();
      frame_start = 1'b1;
      tick();
      frame_start = 1'b0;
      tick();
   endtask

   task automatic do_clear();
      clear = 1'b1;
      tick();
      clear = 1'b0;
      tick();
   endtask

   initial begin
      logic [23:0] exp_a15;
      logic [23:0] exp_a8;
`ifdef TRAJECTORY_FADE_EN
      exp_a15 = 24'h1F1F00;
      exp_a8  = 24'h3F3F00;
`else
      exp_a15 = COL;
      exp_a8  = COL;
`endif
      repeat (3) tick();
      rst = 1'b0;
      tick();

      // Reset state
      expect_cnt(0);
      expect_pix(100, 50, 24'h000000);

      // Single point (100,50): 5x5 dot, edges just outside are clear
      push_point(100, 50);
      expect_cnt(0);
      frame();
      expect_cnt(1);
      for (int dy = -2; dy <= 2; dy++)
         for (int dx = -2; dx <= 2; dx++)
            expect_pix(100 + dx, 50 + dy, COL);
      expect_pix(103, 50, 24'h000000);
      expect_pix(97, 50, 24'h000000);
      expect_pix(100, 53, 24'h000000);

      // Capture in the frame_start cycle waits for the next frame
      frame_start = 1'b1;
      point_valid = 1'b1; point_x = 11'd300; point_y = 10'd300;
      tick();
      frame_start = 1'b0; point_valid = 1'b0;
      tick();
      expect_cnt(1);
      expect_pix(300, 300, 24'h000000);
      frame();
      expect_cnt(2);
      expect_pix(300, 300, COL);

      // Overlapping points (200,200) then (201,200)
      push_point(200, 200); frame();
      push_point(201, 200); frame();
      expect_cnt(4);
      expect_pix(200, 200, COL);
      expect_pix(203, 200, COL);
      expect_pix(198, 200, COL);
      expect_pix(204, 200, 24'h000000);

      // Fifth point, then async reset mid-scan with count=5
      push_point(400, 400); frame();
      expect_cnt(5);
      expect_pix(400, 400, COL);
      tick(); tick();
      rst = 1'b1;
      #1;
      push_exp(1'b1, 24'd0, cyc, 0, 0);
      push_exp(1'b0, 24'h000000, cyc, 400, 400);
      tick(); tick();
      rst = 1'b0;
      tick();
      expect_cnt(0);

      // Last valid point before the commit wins
      push_point(500, 500);
      push_point(510, 510);
      frame();
      expect_cnt(1);
      expect_pix(500, 500, 24'h000000);
      expect_pix(510, 510, COL);

      // Saturation and overwrite: DEPTH+3 points at x=10k, y=100
      do_clear();
      expect_cnt(0);
      for (int k = 0; k < DEPTH + 3; k++) begin
         push_point(10 * k, 100);
         frame();
      end
      expect_cnt(DEPTH);
      expect_pix(0, 100, 24'h000000);
      expect_pix(10, 100, 24'h000000);
      expect_pix(20, 100, 24'h000000);
      expect_pix(30, 100, exp_a15);
      expect_pix(100, 100, exp_a8);
      expect_pix(180, 100, COL);

      // Point at the origin: no wrap to the right edge
      do_clear();
      push_point(0, 0); frame();
      expect_cnt(1);
      for (int v = 0; v <= 2; v++)
         for (int h = 0; h <= 2; h++)
            expect_pix(h, v, COL);
      expect_pix(1279, 0, 24'h000000);
      expect_pix(3, 0, 24'h000000);

      // Clear beats a simultaneous commit and capture
      push_point(5, 5);
      clear = 1'b1; frame_start = 1'b1;
      point_valid = 1'b1; point_x = 11'd7; point_y = 10'd7;
      tick();
      clear = 1'b0; frame_start = 1'b0; point_valid = 1'b0;
      tick();
      expect_cnt(0);
      frame();
      expect_cnt(0);
      expect_pix(7, 7, 24'h000000);
      expect_pix(0, 0, 24'h000000);

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
      tick();
      if (sb.size() != 0) begin
         foreach (sb[i]) begin
            miscompares++;
            $display("FAIL timeout: expectation due at cycle %0d never checked", sb[i].due);
         end
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
